obstacle_motion_ctrl: RTL and testbench
=======================================

Name: obstacle_motion_ctrl

Overview:
- Generates the per-frame position of the moving obstacle inside the game arena. It drives obstacle_x/obstacle_y into draw_obstacles and colision_detector.
- Position advances once per video frame. The obstacle bounces off the arena borders, and its speed rises after a fixed number of frames.
- Starts when play is selected and freezes on game over.
- Sits upstream of draw_obstacles in the pclk domain.

Parameters:
- TOP_V_LINE, 317, arena top line (pixels)
- BOTTOM_V_LINE, 617, arena bottom line
- LEFT_H_LINE, 361, arena left line
- RIGHT_H_LINE, 661, arena right line
- BORDER, 10, inner margin kept clear of arena lines
- OBS_SIZE, 40, obstacle square edge (pixels)
- INIT_SPEED, 2, initial step, pixels/frame per axis
- MAX_SPEED, 8, speed saturation value
- SPEEDUP_FRAMES, 300, frames between speed increments

Ports:
- pclk  in  1  pixel clock (65 MHz)
- rst  in  1  asynchronous, active-low reset
- vsync_in  in  1  vsync from vga_timing; its rising edge is the frame tick
- enable  in  1  play selected / game running
- freeze  in  1  game_over from hp_control
- obstacle_x  out  12  obstacle top-left x
- obstacle_y  out  12  obstacle top-left y
- speed  out  4  current step size
- moving  out  1  high in RUN state
- bounce  out  1  one-cycle pulse on any border hit

Behaviour:
- Derived limits:
  - XMIN=LEFT_H_LINE+BORDER (371), XMAX=RIGHT_H_LINE-BORDER-OBS_SIZE (611)
  - YMIN=TOP_V_LINE+BORDER (327), YMAX=BOTTOM_V_LINE-BORDER-OBS_SIZE (567)
  - XC=(XMIN+XMAX)/2 (491), YC=(YMIN+YMAX)/2 (447)
- Reset (rst low, async):
  - obstacle_x=XC, obstacle_y=YC, speed=INIT_SPEED
  - dx=+1, dy=+1, frame counter=0
  - moving=0, bounce=0, state IDLE, vsync_prev=0
- Frame tick: tick = vsync_in & ~vsync_prev, where vsync_prev is a register. Position updates on the same pclk edge that first samples vsync_in high, i.e. 1-cycle latency from the vsync rise.
- FSM:
  - IDLE: outputs hold the reset values. Go to RUN when enable=1.
  - RUN: moving=1. On each tick, update the position, the frame counter and speed.
    - If enable=0, go to IDLE and reload the reset values (except that vsync_prev keeps tracking vsync_in).
    - Else if freeze=1, go to FROZEN.
  - FROZEN: moving=0; position and speed held; ticks ignored. Go to IDLE when enable=0. freeze deassertion alone does not resume.
  - Priority in RUN: enable=0 beats freeze=1, which beats tick. If freeze and tick arrive in the same cycle, no move occurs.
- Per-axis update on tick (x shown; y identical with YMIN/YMAX and dy):
  - dx=+1 and x+speed >= XMAX: x=XMAX, dx=-1, bounce.
  - dx=-1 and x-speed <= XMIN: x=XMIN, dx=+1, bounce.
  - Otherwise x = x ± speed.
  - Arithmetic is 12-bit unsigned. The clamp makes the result always lie in [XMIN, XMAX]; there is no wrap.
- Simultaneous x and y hits: both directions flip and bounce is a single one-cycle pulse.
- bounce is registered, high for exactly the one cycle following the update edge, and 0 outside RUN.
- Speed-up:
  - The frame counter increments on each RUN tick.
  - At SPEEDUP_FRAMES-1 the counter clears to 0 and speed = min(speed+1, MAX_SPEED).
  - The new speed applies from the next tick.
  - The counter holds in FROZEN and clears in IDLE.
- A tick arriving in the same cycle as the IDLE→RUN transition is not applied; the first move happens on the next tick.

Decomposition:
- Shared package/header holds:
  - arena constants (TOP_V_LINE, BOTTOM_V_LINE, LEFT_H_LINE, RIGHT_H_LINE)
  - OBS_SIZE
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, FROZEN=2'd2)
- Sub-module frame_tick_gen: vsync rising-edge detector (pclk, rst, vsync_in → tick). It is reusable by hp_control.
- Per-axis bounce arithmetic is a single function or generate block, instantiated for x and y.

Test Plan:
- Reset values: assert rst low mid-RUN → outputs immediately x=491, y=447, speed=2, moving=0, bounce=0; after release with enable=0 the outputs stay there.
- First move: enable=1, then one vsync rise → after the update edge x=493, y=449, moving=1; no change between ticks.
- Simultaneous bounce: 60 ticks from centre → x=611, y=567, bounce high for exactly 1 cycle, one pulse total; tick 61 → x=609, y=565.
- Speed-up: 300 ticks → speed=3, and tick 301 steps by 3. Keep running → speed saturates at 8 and never exceeds it; x and y stay within [371,611] and [327,567] throughout.
- Freeze: freeze=1 with a tick in the same cycle → no move, moving=0. Further ticks → position held. freeze=0 → still frozen. enable=0 → IDLE, x=491, y=447, speed=2.
- Abort: enable drops mid-RUN → IDLE next edge with centre restored and counter cleared; re-enable plus a tick in the enable cycle → no move until the following tick.

Source files
------------

// File: rtl/obstacle_motion_ctrl_pkg.sv
// Shared constants, FSM encoding and per-axis bounce arithmetic for obstacle_motion_ctrl.
// Latency: n/a (package). Backpressure: n/a.
// Contents: arena geometry, derived position limits, state_t, axis_t, axis_step().
package obstacle_motion_ctrl_pkg;

  // Arena geometry (pixels)
  localparam int TOP_V_LINE     = 317;
  localparam int BOTTOM_V_LINE  = 617;
  localparam int LEFT_H_LINE    = 361;
  localparam int RIGHT_H_LINE   = 661;
  localparam int BORDER         = 10;
  localparam int OBS_SIZE       = 40;

  // Motion tuning
  localparam int INIT_SPEED     = 2;
  localparam int MAX_SPEED      = 8;
  localparam int SPEEDUP_FRAMES = 300;

  // Allowed range of the obstacle top-left corner
  localparam int XMIN_I = LEFT_H_LINE + BORDER;
  localparam int XMAX_I = RIGHT_H_LINE - BORDER - OBS_SIZE;
  localparam int YMIN_I = TOP_V_LINE + BORDER;
  localparam int YMAX_I = BOTTOM_V_LINE - BORDER - OBS_SIZE;

  localparam logic [11:0] XMIN = 12'(XMIN_I);
  localparam logic [11:0] XMAX = 12'(XMAX_I);
  localparam logic [11:0] YMIN = 12'(YMIN_I);
  localparam logic [11:0] YMAX = 12'(YMAX_I);
  localparam logic [11:0] XC   = 12'((XMIN_I + XMAX_I) / 2);
  localparam logic [11:0] YC   = 12'((YMIN_I + YMAX_I) / 2);

  localparam logic [3:0]  SPEED_INIT = 4'(INIT_SPEED);
  localparam logic [3:0]  SPEED_MAX  = 4'(MAX_SPEED);
  localparam logic [8:0]  FRAME_LAST = 9'(SPEEDUP_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_t;

  // Result of one axis step: new position, new direction (1 = increasing), border hit
  typedef struct packed {
    logic [11:0] pos;
    logic        dir;
    logic        hit;
  } axis_t;

  // One frame of motion along a single axis. The clamp onto the limit keeps the
  // result inside [lo, hi], so the unsigned arithmetic can never wrap for
  // positions that start inside the range.
  function automatic axis_t axis_step(input logic [11:0] pos,
                                      input logic        dir,
                                      input logic [3:0]  spd,
                                      input logic [11:0] lo,
                                      input logic [11:0] hi);
    axis_t       r;
    logic [11:0] s;
    s     = {8'd0, spd};
    r.pos = pos;
    r.dir = dir;
    r.hit = 1'b0;
    if (dir) begin
      if (pos + s >= hi) begin
        r.pos = hi;
        r.dir = 1'b0;
        r.hit = 1'b1;
      end else begin
        r.pos = pos + s;
      end
    end else begin
      if (pos - s <= lo) begin
        r.pos = lo;
        r.dir = 1'b1;
        r.hit = 1'b1;
      end else begin
        r.pos = pos - s;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/obstacle_motion_ctrl_if.sv
// Control inputs and position outputs of the obstacle motion controller.
// Latency: n/a (wiring only). Backpressure: none, outputs are level signals.
// Ports: vsync_in/enable/freeze from the game, obstacle_x/y, speed, moving, bounce back.
interface obstacle_motion_ctrl_if;
  import obstacle_motion_ctrl_pkg::*;

  logic        vsync_in;
  logic        enable;
  logic        freeze;
  logic [11:0] obstacle_x;
  logic [11:0] obstacle_y;
  logic [3:0]  speed;
  logic        moving;
  logic        bounce;

  // Game-side view: drives the controls, consumes the position
  modport master (
    output vsync_in, enable, freeze,
    input  obstacle_x, obstacle_y, speed, moving, bounce
  );

  // Motion-controller view
  modport slave (
    input  vsync_in, enable, freeze,
    output obstacle_x, obstacle_y, speed, moving, bounce
  );
endinterface

// File: rtl/obstacle_motion_ctrl_frame_tick_gen.sv
// Rising-edge detector on vsync producing a one-cycle frame tick.
// Latency: tick is combinational in the cycle vsync_in is first sampled high. Backpressure: none.
// Ports: pclk, rst (async active-low), vsync_in -> tick.
module frame_tick_gen (
  input  logic pclk,
  input  logic rst,
  input  logic vsync_in,
  output logic tick
);

  logic vsync_prev;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vsync_prev <= 1'b0;
    end else begin
      vsync_prev <= vsync_in;
    end
  end

  assign tick = vsync_in & ~vsync_prev;

endmodule

// File: rtl/obstacle_motion_ctrl.sv
// Per-frame position of the bouncing obstacle, with periodic speed-up.
// Latency: position updates on the pclk edge that first samples vsync high. Backpressure: none.
// Ports: pclk, rst (async active-low), obs (slave modport: controls in, position/status out).
module obstacle_motion_ctrl
  import obstacle_motion_ctrl_pkg::*;
(
  input  logic                   pclk,
  input  logic                   rst,
  obstacle_motion_ctrl_if.slave  obs
);

  logic        tick;
  state_t      state;
  logic [11:0] pos_x;
  logic [11:0] pos_y;
  logic        dir_x;
  logic        dir_y;
  logic [3:0]  spd;
  logic [8:0]  frame_cnt;
  logic        moving_q;
  logic        bounce_q;
  axis_t       nx;
  axis_t       ny;

  frame_tick_gen u_frame_tick_gen (
    .pclk     (pclk),
    .rst      (rst),
    .vsync_in (obs.vsync_in),
    .tick     (tick)
  );

  // Candidate next positions; only committed on a RUN tick
  always_comb begin
    nx = axis_step(pos_x, dir_x, spd, XMIN, XMAX);
    ny = axis_step(pos_y, dir_y, spd, YMIN, YMAX);
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pos_x     <= XC;
      pos_y     <= YC;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      spd       <= SPEED_INIT;
      frame_cnt <= '0;
      moving_q  <= 1'b0;
      bounce_q  <= 1'b0;
    end else begin
      bounce_q <= 1'b0;
      case (state)
        IDLE: begin
          // A tick coinciding with enable is deliberately dropped here
          if (obs.enable) begin
            state    <= RUN;
            moving_q <= 1'b1;
          end
        end

        RUN: begin
          if (!obs.enable) begin
            state     <= IDLE;
            moving_q  <= 1'b0;
            pos_x     <= XC;
            pos_y     <= YC;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            spd       <= SPEED_INIT;
            frame_cnt <= '0;
          end else if (obs.freeze) begin
            state    <= FROZEN;
            moving_q <= 1'b0;
          end else if (tick) begin
            pos_x    <= nx.pos;
            dir_x    <= nx.dir;
            pos_y    <= ny.pos;
            dir_y    <= ny.dir;
            // Corner hits merge into a single pulse
            bounce_q <= nx.hit | ny.hit;
            if (frame_cnt == FRAME_LAST) begin
              frame_cnt <= '0;
              if (spd < SPEED_MAX) begin
                spd <= spd + 4'd1;
              end
            end else begin
              frame_cnt <= frame_cnt + 9'd1;
            end
          end
        end

        FROZEN: begin
          // Only dropping enable leaves FROZEN; releasing freeze does not resume
          if (!obs.enable) begin
            state     <= IDLE;
            pos_x     <= XC;
            pos_y     <= YC;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            spd       <= SPEED_INIT;
            frame_cnt <= '0;
          end
        end

        default: begin
          state    <= IDLE;
          moving_q <= 1'b0;
        end
      endcase
    end
  end

  assign obs.obstacle_x = pos_x;
  assign obs.obstacle_y = pos_y;
  assign obs.speed      = spd;
  assign obs.moving     = moving_q;
  assign obs.bounce     = bounce_q;

endmodule

// File: tb/tb_obstacle_motion_ctrl.sv
// Self-checking bench for obstacle_motion_ctrl: behavioural model plus directed literals.
// Latency: n/a. Backpressure: n/a.
// Drives the interface as game master; compares every cycle on the falling edge.
module tb_obstacle_motion_ctrl;

  logic pclk;
  logic rst;

  obstacle_motion_ctrl_if bus ();

  obstacle_motion_ctrl dut (
    .pclk (pclk),
    .rst  (rst),
    .obs  (bus.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_fail   = 0;
  int bounce_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 running, 2 frozen; direction as +1/-1; frames counts 1..300
  int m_mode, m_x, m_y, m_dx, m_dy, m_spd, m_frames, m_bounce;
  bit m_vs_prev;

  function automatic int travel(input int p, input int d, input int s,
                                input int lo, input int hi);
    if (d > 0) return (p + s > hi) ? hi : p + s;
    else       return (p - s < lo) ? lo : p - s;
  endfunction

  task automatic m_home();
    m_x = 491; m_y = 447; m_dx = 1; m_dy = 1; m_spd = 2; m_frames = 0;
  endtask

  always @(posedge pclk or negedge rst) begin
    bit tk;
    if (!rst) begin
      m_mode = 0; m_bounce = 0; m_vs_prev = 0;
      m_home();
    end else begin
      tk = bus.vsync_in && !m_vs_prev;
      m_vs_prev = bus.vsync_in;
      m_bounce = 0;
      if (m_mode == 0) begin
        if (bus.enable) m_mode = 1;
      end else if (m_mode == 1) begin
        if (!bus.enable) begin
          m_mode = 0; m_home();
        end else if (bus.freeze) begin
          m_mode = 2;
        end else if (tk) begin
          m_x = travel(m_x, m_dx, m_spd, 371, 611);
          m_y = travel(m_y, m_dy, m_spd, 327, 567);
          if ((m_dx > 0 && m_x == 611) || (m_dx < 0 && m_x == 371)) begin
            m_dx = -m_dx; m_bounce = 1;
          end
          if ((m_dy > 0 && m_y == 567) || (m_dy < 0 && m_y == 327)) begin
            m_dy = -m_dy; m_bounce = 1;
          end
          m_frames++;
          if (m_frames == 300) begin
            m_frames = 0;
            if (m_spd < 8) m_spd++;
          end
        end
      end else begin
        if (!bus.enable) begin
          m_mode = 0; m_home();
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge pclk) begin
    check("x",      int'(bus.obstacle_x), m_x);
    check("y",      int'(bus.obstacle_y), m_y);
    check("speed",  int'(bus.speed),      m_spd);
    check("moving", int'(bus.moving),     (m_mode == 1) ? 1 : 0);
    check("bounce", int'(bus.bounce),     m_bounce);
    check("x_range", int'(bus.obstacle_x >= 12'd371 && bus.obstacle_x <= 12'd611), 1);
    check("y_range", int'(bus.obstacle_y >= 12'd327 && bus.obstacle_y <= 12'd567), 1);
    check("speed_cap", int'(bus.speed <= 4'd8), 1);
    if (bus.bounce) bounce_seen++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk);
      #2;
    end
  endtask

  // One vsync pulse; the update edge is the first posedge after the rise
  task automatic frame();
    cyc(1);
    bus.vsync_in = 1'b1;
    cyc(2);
    bus.vsync_in = 1'b0;
    cyc(1);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int sx, sy;
    rst = 1'b0;
    bus.vsync_in = 1'b0;
    bus.enable   = 1'b0;
    bus.freeze   = 1'b0;
    #23;
    rst = 1'b1;
    cyc(3);
    check("reset_x", int'(bus.obstacle_x), 491);
    check("reset_y", int'(bus.obstacle_y), 447);
    check("reset_speed", int'(bus.speed), 2);
    check("reset_moving", int'(bus.moving), 0);
    frame();
    check("idle_tick_x", int'(bus.obstacle_x), 491);

    // First move
    bus.enable = 1'b1;
    cyc(2);
    frame();
    check("first_x", int'(bus.obstacle_x), 493);
    check("first_y", int'(bus.obstacle_y), 449);
    check("first_moving", int'(bus.moving), 1);
    cyc(5);
    check("hold_x", int'(bus.obstacle_x), 493);

    // Corner hit after 60 ticks from centre
    bounce_seen = 0;
    frames(59);
    check("corner_x", int'(bus.obstacle_x), 611);
    check("corner_y", int'(bus.obstacle_y), 567);
    check("corner_pulses", bounce_seen, 1);
    frame();
    check("after_corner_x", int'(bus.obstacle_x), 609);
    check("after_corner_y", int'(bus.obstacle_y), 565);

    // Speed-up at tick 300, new speed from tick 301
    frames(239);
    check("speedup_speed", int'(bus.speed), 3);
    frame();
    check("tick301_x", int'(bus.obstacle_x), 608);
    check("tick301_y", int'(bus.obstacle_y), 564);

    // Saturation
    frames(1799);
    check("sat_speed", int'(bus.speed), 8);

    // Freeze with a coincident tick
    sx = int'(bus.obstacle_x);
    sy = int'(bus.obstacle_y);
    bus.freeze   = 1'b1;
    bus.vsync_in = 1'b1;
    cyc(1);
    check("freeze_x", int'(bus.obstacle_x), sx);
    check("freeze_y", int'(bus.obstacle_y), sy);
    check("freeze_moving", int'(bus.moving), 0);
    bus.vsync_in = 1'b0;
    frames(3);
    check("frozen_x", int'(bus.obstacle_x), sx);
    bus.freeze = 1'b0;
    frames(3);
    check("unfreeze_x", int'(bus.obstacle_x), sx);
    check("unfreeze_moving", int'(bus.moving), 0);
    bus.enable = 1'b0;
    cyc(1);
    check("exit_frozen_x", int'(bus.obstacle_x), 491);
    check("exit_frozen_y", int'(bus.obstacle_y), 447);
    check("exit_frozen_speed", int'(bus.speed), 2);

    // Abort mid-run
    bus.enable = 1'b1;
    cyc(1);
    frames(3);
    check("abort_pre_x", int'(bus.obstacle_x), 497);
    check("abort_pre_y", int'(bus.obstacle_y), 453);
    bus.enable = 1'b0;
    cyc(1);
    check("abort_x", int'(bus.obstacle_x), 491);
    check("abort_moving", int'(bus.moving), 0);
    bus.enable   = 1'b1;
    bus.vsync_in = 1'b1;
    cyc(1);
    check("reenable_x", int'(bus.obstacle_x), 491);
    check("reenable_moving", int'(bus.moving), 1);
    bus.vsync_in = 1'b0;
    cyc(1);
    frame();
    check("reenable_first_x", int'(bus.obstacle_x), 493);
    frames(298);
    check("cnt_cleared_speed", int'(bus.speed), 2);
    frame();
    check("cnt_cleared_speedup", int'(bus.speed), 3);

    // Asynchronous reset mid-run
    rst = 1'b0;
    #1;
    check("arst_x", int'(bus.obstacle_x), 491);
    check("arst_y", int'(bus.obstacle_y), 447);
    check("arst_speed", int'(bus.speed), 2);
    check("arst_moving", int'(bus.moving), 0);
    check("arst_bounce", int'(bus.bounce), 0);
    bus.enable = 1'b0;
    cyc(2);
    rst = 1'b1;
    frames(2);
    check("post_rst_x", int'(bus.obstacle_x), 491);
    check("post_rst_moving", int'(bus.moving), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
